// File: rtl/alu_scoreboard.sv
// In-order scoreboard for the 8-bit ALU: buffers expected results at request time
// and checks DUT responses against the oldest entry, keeping pass/fail statistics.
module alu_scoreboard #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         req_valid,
  input  logic [7:0]                   req_a,
  input  logic [7:0]                   req_b,
  input  logic [2:0]                   req_op,
  output logic                         req_ready,
  input  logic                         rsp_valid,
  input  logic [7:0]                   rsp_result,
  output logic [$clog2(DEPTH+1)-1:0]   pending,
  output logic [CNT_W-1:0]             pass_count,
  output logic [CNT_W-1:0]             fail_count,
  output logic                         mismatch,
  output logic [2:0]                   mismatch_op,
  output logic [7:0]                   mismatch_exp,
  output logic [7:0]                   mismatch_got,
  output logic                         overflow_err,
  output logic                         underflow_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] exp;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  entry_t             new_entry;
  entry_t             head;
  logic               head_match;

  // Reference model of the ALU, evaluated when the request is captured.
  function automatic logic [7:0] alu_model(input logic [2:0] op,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
    logic [15:0] prod;
    logic [7:0]  res;
    prod = 16'(a) * 16'(b);
    res  = 8'h00;
    case (op)
      3'b000:  res = a + b;
      3'b001:  res = a - b;
      3'b010:  res = a & b;
      3'b011:  res = a | b;
      3'b100:  res = prod[7:0];
      default: res = 8'h00;
    endcase
    return res;
  endfunction

  always_comb begin
    full          = (pending == FULL_OCC);
    empty         = (pending == '0);
    pop           = rsp_valid && !empty;
    push          = req_valid && (!full || pop);
    req_ready     = !full;
    new_entry.op  = req_op;
    new_entry.exp = alu_model(req_op, req_a, req_b);
    head          = mem[rd_ptr];
    head_match    = (head.exp == rsp_result);
  end

  // Storage carries no reset; validity is tracked by the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  // Pointers and occupancy; clear deliberately leaves the queue intact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pending <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   pending <= pending + OCC_W'(1);
        2'b01:   pending <= pending - OCC_W'(1);
        default: pending <= pending;
      endcase
    end
  end

  // Compare results, saturating statistics, failure capture and sticky errors.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass_count    <= '0;
      fail_count    <= '0;
      mismatch      <= 1'b0;
      mismatch_op   <= '0;
      mismatch_exp  <= '0;
      mismatch_got  <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (clear) begin
      pass_count    <= '0;
      fail_count    <= '0;
      mismatch      <= 1'b0;
      mismatch_op   <= '0;
      mismatch_exp  <= '0;
      mismatch_got  <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      if (pop) begin
        if (head_match) begin
          if (pass_count != '1) pass_count <= pass_count + CNT_W'(1);
        end else begin
          if (fail_count != '1) fail_count <= fail_count + CNT_W'(1);
          mismatch     <= 1'b1;
          mismatch_op  <= head.op;
          mismatch_exp <= head.exp;
          mismatch_got <= rsp_result;
        end
      end
      if (req_valid && full && !pop) overflow_err  <= 1'b1;
      if (rsp_valid && empty)        underflow_err <= 1'b1;
    end
  end

endmodule

// File: doc/alu_scoreboard.md
# alu_scoreboard

In-order checking scoreboard for the 8-bit ALU datapath. It captures each operation the DUT accepts, computes and buffers the expected result in a FIFO, and consumes DUT results in issue order. Each result is compared against the oldest expected entry, and the block keeps pass/fail statistics and sticky protocol errors. It sits on the bench side, between the ALU stimulus interface and the ALU result interface.

## Interface
- DEPTH, 8, expected-result FIFO entries; power of two, ≥2
- CNT_W, 16, width of pass/fail counters
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- clear  in  1  synchronous clear of counters, sticky errors and capture registers; FIFO untouched
- req_valid  in  1  DUT accepted an operation this cycle
- req_a  in  8  operand A
- req_b  in  8  operand B
- req_op  in  3  opcode
- req_ready  out  1  FIFO not full (combinational from occupancy)
- rsp_valid  in  1  DUT result presented this cycle
- rsp_result  in  8  DUT result
- pending  out  $clog2(DEPTH+1)  current FIFO occupancy
- pass_count  out  CNT_W  matching compares, saturating
- fail_count  out  CNT_W  mismatching compares, saturating
- mismatch  out  1  one-cycle pulse per failed compare
- mismatch_op  out  3  opcode of most recent failure
- mismatch_exp  out  8  expected value of most recent failure
- mismatch_got  out  8  DUT value of most recent failure
- overflow_err  out  1  sticky: push attempted while full with no simultaneous pop
- underflow_err  out  1  sticky: rsp_valid while FIFO empty

## Operation
- Expected function, evaluated at push and truncated to 8 bits:
  - 000: A+B
  - 001: A−B (two's complement wrap)
  - 010: A&B
  - 011: A|B
  - 100: low 8 bits of A*B
  - 101–111: 8'h00
- FIFO entry holds {op, expected}. Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; full/empty are derived from the pending count.
- Push: req_valid=1 and (not full, or a pop occurs in the same cycle).
- Pop and compare: rsp_valid=1 and FIFO non-empty at the clock edge. The head entry is compared against rsp_result and the read pointer advances.
  - Equal: pass_count increments.
  - Not equal: fail_count increments, mismatch pulses, and mismatch_op/exp/got are captured.
- Push and pop in the same cycle: both occur and pending is unchanged. When full, the pop frees the slot and the push is accepted.
- rsp_valid while empty: no compare and no counter change; underflow_err is set. There is no bypass, so a request pushed in the same cycle is still enqueued.
- req_valid while full without a pop: the request is dropped and overflow_err is set.
- Counters saturate at 2^CNT_W−1 and do not wrap.
- clear has priority over counter updates. In a clear cycle the compare result is discarded, but any push or pop still takes place. mismatch is 0 in the cycle following a clear.
- Opcode decode has no state machine. The only state is the FIFO, the pointers, the counters, the capture registers and the sticky flags.

## Timing
- Reset (asynchronous, immediate), all outputs:
  - pending=0
  - pass_count=0, fail_count=0
  - mismatch=0
  - mismatch_op=0, mismatch_exp=0, mismatch_got=0
  - overflow_err=0, underflow_err=0
  - req_ready=1
  - FIFO contents are don't-care.
- Reset mid-stream discards all pending entries. The first response after reset with no new request sets underflow_err.
- All outputs except req_ready are registered. Updates are visible in the cycle after the sampling edge.
- Latency from push to earliest possible compare is one cycle: a response in the cycle after the push is checked against that push.
- mismatch is high for exactly one cycle per failing compare. Back-to-back failures keep it high on consecutive cycles, and each failure overwrites the capture registers.

## Test plan
- Reset, then push op=000 A=8'hF0 B=8'h20, then rsp 8'h10 -> pass_count=1, fail_count=0, mismatch=0, pending back to 0.
- Push op=100 A=8'h10 B=8'h11, then rsp 8'h00 -> fail_count=1, one-cycle mismatch pulse, mismatch_op=100, mismatch_exp=8'h10, mismatch_got=8'h00.
- Push 8 requests without responses (DEPTH=8) -> req_ready=0 and pending=8. A 9th push -> overflow_err=1 and pending stays 8. A push with a simultaneous rsp -> accepted and pending stays 8.
- rsp_valid with empty FIFO -> underflow_err=1 and counters unchanged. Then assert clear -> both error flags and both counters return to 0.
- Ops 001 (A=8'h00, B=8'h01 -> 8'hFF), 010, 011 and 111 (-> 8'h00) with correct responses, including back-to-back push/pop every cycle -> pass_count=4, fail_count=0.
- Assert reset with 3 entries pending -> all outputs return to reset values immediately. A following rsp -> underflow_err=1.
